mul_unit: RTL and testbench

Multi-cycle multiply / multiply-accumulate unit that executes the HI/LO-class operations selected by the instruction decoder (SPECIAL MULT/MULTU/MFHI/MFLO/MTHI/MTLO and SPECIAL2 MADD/MADDU/MSUB/MSUBU/MUL). It sits beside the ALU in the execute stage and owns the architectural HI and LO registers. It also provides a Busy stall handshake back to the pipeline control.

---
 rtl/mul_unit.sv | 194 +++++++++++++++++++
 tb/tb_mul_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_unit
// Purpose  : Multi-cycle multiply / multiply-accumulate unit owning the
//            architectural HI/LO registers. Radix-2 shift-add core, 32
//            iterations, with a Busy/Done handshake to pipeline control.
// Revision : 1.0 - initial release
// ============================================================================
module mul_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        special2_i,
  input  logic [5:0]  func_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_MADD  = 4'd3,
    OP_MADDU = 4'd4,
    OP_MSUB  = 4'd5,
    OP_MSUBU = 4'd6,
    OP_MUL   = 4'd7,
    OP_MFHI  = 4'd8,
    OP_MTHI  = 4'd9,
    OP_MFLO  = 4'd10,
    OP_MTLO  = 4'd11
  } op_t;

  state_t      state_q,  state_d;
  op_t         op_q,     op_d;
  logic [4:0]  cnt_q,    cnt_d;
  logic [63:0] mcand_q,  mcand_d;   // multiplicand, shifted left each step
  logic [31:0] mplier_q, mplier_d;  // multiplier, shifted right each step
  logic [63:0] prod_q,   prod_d;    // unsigned partial product (magnitude)
  logic        sign_q,   sign_d;
  logic [31:0] hi_q,     hi_d;
  logic [31:0] lo_q,     lo_d;
  logic [31:0] result_q, result_d;
  logic        done_q,   done_d;

  op_t         op_dec;
  logic        op_signed;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] prod_final;

  // Decode {Special2,Func} into an internal opcode; OP_NONE marks illegal codes
  always_comb begin
    op_dec = OP_NONE;
    if (special2_i) begin
      case (func_i)
        6'b000000: op_dec = OP_MADD;
        6'b000001: op_dec = OP_MADDU;
        6'b000010: op_dec = OP_MUL;
        6'b000100: op_dec = OP_MSUB;
        6'b000101: op_dec = OP_MSUBU;
        default:   op_dec = OP_NONE;
      endcase
    end else begin
      case (func_i)
        6'b011000: op_dec = OP_MULT;
        6'b011001: op_dec = OP_MULTU;
        6'b010000: op_dec = OP_MFHI;
        6'b010001: op_dec = OP_MTHI;
        6'b010010: op_dec = OP_MFLO;
        6'b010011: op_dec = OP_MTLO;
        default:   op_dec = OP_NONE;
      endcase
    end
  end

  // Signed ops multiply magnitudes and re-apply the sign at the end
  assign op_signed  = (op_dec == OP_MULT) || (op_dec == OP_MADD) ||
                      (op_dec == OP_MSUB) || (op_dec == OP_MUL);
  assign mag_a      = (op_signed && a_i[31]) ? (~a_i + 32'd1) : a_i;
  assign mag_b      = (op_signed && b_i[31]) ? (~b_i + 32'd1) : b_i;
  assign prod_final = sign_q ? (~prod_q + 64'd1) : prod_q;

  // Next-state and datapath logic; everything holds unless updated below
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    sign_d   = sign_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && (op_dec != OP_NONE)) begin
          case (op_dec)
            OP_MTHI: begin hi_d     = a_i;  done_d = 1'b1; end
            OP_MTLO: begin lo_d     = a_i;  done_d = 1'b1; end
            OP_MFHI: begin result_d = hi_q; done_d = 1'b1; end
            OP_MFLO: begin result_d = lo_q; done_d = 1'b1; end
            default: begin
              op_d     = op_dec;
              sign_d   = op_signed & (a_i[31] ^ b_i[31]);
              mcand_d  = {32'd0, mag_a};
              mplier_d = mag_b;
              prod_d   = 64'd0;
              cnt_d    = 5'd0;
              state_d  = S_CALC;
            end
          endcase
        end
      end

      S_CALC: begin
        if (mplier_q[0]) begin
          prod_d = prod_q + mcand_q;
        end
        mcand_d  = {mcand_q[62:0], 1'b0};
        mplier_d = {1'b0, mplier_q[31:1]};
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        case (op_q)
          OP_MULT, OP_MULTU: {hi_d, lo_d} = prod_final;
          OP_MADD, OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_final;
          OP_MSUB, OP_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod_final;
          OP_MUL:            result_d     = prod_final[31:0];
          default:           result_d     = result_q;
        endcase
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset discarding any in-flight operation
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NONE;
      cnt_q    <= 5'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      prod_q   <= 64'd0;
      sign_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      sign_q   <= sign_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_unit
// Purpose  : Self-checking bench for mul_unit: vector table, random
//            multiplies against a behavioural model, and hand-written
//            back-to-back / reset / illegal-code sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_unit;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MADD  = 6'h00;
  localparam logic [5:0] F_MADDU = 6'h01;
  localparam logic [5:0] F_MUL   = 6'h02;
  localparam logic [5:0] F_MSUB  = 6'h04;
  localparam logic [5:0] F_MSUBU = 6'h05;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        special2;
  logic [5:0]  func;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  mul_unit dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .special2_i (special2),
    .func_i     (func),
    .a_i        (a),
    .b_i        (b),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (result),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] eh;
    logic [31:0] el;
    logic [31:0] er;
  } exp_t;

  typedef struct {
    logic        preset;
    logic [31:0] ph;
    logic [31:0] pl;
    logic        sp2;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    logic [31:0] er;
    logic        multi;
  } vec_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] m_res = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every Done pulse pops one expected record
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got Done=1, expected no Done");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi_at_done", hi, e.eh);
        check("lo_at_done", lo, e.el);
        check("result_at_done", result, e.er);
      end
    end
  end

  // Issue one operation, push its expectation, and measure the Busy window
  task automatic issue(input logic sp2, input logic [5:0] f, input logic [31:0] ia,
                       input logic [31:0] ib, input logic [31:0] eh, input logic [31:0] el,
                       input logic [31:0] er, input logic multi);
    int   cyc;
    exp_t e;
    @(negedge clk);
    start = 1'b1; special2 = sp2; func = f; a = ia; b = ib;
    e.eh = eh; e.el = el; e.er = er;
    sb.push_back(e);
    m_hi = eh; m_lo = el; m_res = er;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_cycles", cyc, multi ? 32'd33 : 32'd0);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    sb.delete();
  endtask

  function automatic logic [63:0] model_prod(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    if (sgn) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return sx * sy;
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  vec_t vecs[14];

  initial begin
    rst = 1'b1; start = 1'b0; special2 = 1'b0; func = 6'd0; a = 32'd0; b = 32'd0;

    //             preset ph            pl            sp2   func     a             b             eh            el            er            multi
    vecs[0]  = '{1'b0, 32'h0,        32'h0,        1'b0, F_MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h0,        32'h0,        1'b0, F_MFHI,  32'h0,        32'h0,        32'h12345678, 32'h0,        32'h12345678, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,        32'h0,        1'b0, F_MULT,  32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, 32'h12345678, 1'b1};
    vecs[3]  = '{1'b0, 32'h0,        32'h0,        1'b0, F_MULTU, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 32'h12345678, 1'b1};
    vecs[4]  = '{1'b0, 32'h0,        32'h0,        1'b0, F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        32'h12345678, 1'b1};
    vecs[5]  = '{1'b1, 32'h0,        32'hFFFFFFFF, 1'b1, F_MADDU, 32'h1,        32'h1,        32'h00000001, 32'h0,        32'h12345678, 1'b1};
    vecs[6]  = '{1'b0, 32'h0,        32'h0,        1'b1, F_MSUB,  32'h2,        32'h3,        32'h0,        32'hFFFFFFFA, 32'h12345678, 1'b1};
    vecs[7]  = '{1'b1, 32'hAAAA5555, 32'h5555AAAA, 1'b1, F_MUL,   32'hFFFFFFFD, 32'h7,        32'hAAAA5555, 32'h5555AAAA, 32'hFFFFFFEB, 1'b1};
    vecs[8]  = '{1'b0, 32'h0,        32'h0,        1'b0, F_MFLO,  32'h0,        32'h0,        32'hAAAA5555, 32'h5555AAAA, 32'h5555AAAA, 1'b0};
    vecs[9]  = '{1'b1, 32'h0,        32'h0,        1'b1, F_MADD,  32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB, 32'h5555AAAA, 1'b1};
    vecs[10] = '{1'b1, 32'h0,        32'h0,        1'b1, F_MSUBU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h5555AAAA, 1'b1};
    vecs[11] = '{1'b0, 32'h0,        32'h0,        1'b0, F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'h5555AAAA, 1'b1};
    vecs[12] = '{1'b0, 32'h0,        32'h0,        1'b0, F_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 32'h5555AAAA, 1'b1};
    vecs[13] = '{1'b0, 32'h0,        32'h0,        1'b0, F_MTLO,  32'h13579BDF, 32'h0,        32'hC0000000, 32'h13579BDF, 32'h5555AAAA, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].preset) begin
        issue(1'b0, F_MTHI, vecs[i].ph, 32'd0, vecs[i].ph, m_lo, m_res, 1'b0);
        issue(1'b0, F_MTLO, vecs[i].pl, 32'd0, vecs[i].ph, vecs[i].pl, m_res, 1'b0);
      end
      issue(vecs[i].sp2, vecs[i].f, vecs[i].a, vecs[i].b,
            vecs[i].eh, vecs[i].el, vecs[i].er, vecs[i].multi);
    end

    // Random multiplies / accumulates checked against a behavioural model
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      logic [63:0] p, acc;
      int          sel;
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 3);
      acc = {m_hi, m_lo};
      case (sel)
        0: begin p = model_prod(1'b1, ra, rb); issue(1'b0, F_MULT,  ra, rb, p[63:32], p[31:0], m_res, 1'b1); end
        1: begin p = model_prod(1'b0, ra, rb); issue(1'b0, F_MULTU, ra, rb, p[63:32], p[31:0], m_res, 1'b1); end
        2: begin p = acc + model_prod(1'b1, ra, rb); issue(1'b1, F_MADD,  ra, rb, p[63:32], p[31:0], m_res, 1'b1); end
        default: begin p = acc - model_prod(1'b0, ra, rb); issue(1'b1, F_MSUBU, ra, rb, p[63:32], p[31:0], m_res, 1'b1); end
      endcase
    end

    // Back-to-back: MFHI presented in the Done cycle sees the new Hi
    begin
      exp_t e;
      int   cyc;
      @(negedge clk);
      start = 1'b1; special2 = 1'b0; func = F_MULT; a = 32'h00010000; b = 32'h00030000;
      e.eh = 32'h3; e.el = 32'h0; e.er = m_res;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (busy && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      check("b2b_busy_cycles", cyc, 32'd33);
      check("b2b_done_high", {31'd0, done}, 32'd1);
      start = 1'b1; func = F_MFHI;
      e.eh = 32'h3; e.el = 32'h0; e.er = 32'h3;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      check("b2b_mfhi_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("b2b_scoreboard_drained", sb.size(), 32'd0);
      sb.delete();
    end

    // Preset Lo, then MULT with an MTLO pulsed while Busy and reset at counter 10
    issue(1'b0, F_MTLO, 32'h13579BDF, 32'd0, 32'h3, 32'h13579BDF, 32'h3, 1'b0);
    @(negedge clk);
    start = 1'b1; special2 = 1'b0; func = F_MULT; a = 32'h5; b = 32'h6;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; func = F_MTLO; a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_while_busy_busy", {31'd0, busy}, 32'd1);
    repeat (4) @(negedge clk);
    check("mtlo_while_busy_lo", lo, 32'h13579BDF);
    check("mid_calc_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_late_busy", {31'd0, busy}, 32'd0);

    // Illegal code: no state change, no Done
    issue(1'b0, F_MTHI, 32'h0BADF00D, 32'd0, 32'h0BADF00D, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    start = 1'b1; special2 = 1'b1; func = 6'b111111; a = 32'h11111111; b = 32'h22222222;
    @(negedge clk);
    start = 1'b0;
    check("illegal_busy", {31'd0, busy}, 32'd0);
    check("illegal_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    check("illegal_hi", hi, 32'h0BADF00D);
    check("illegal_lo", lo, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
